// File: rtl/alarm_clock_pkg.sv
// Shared constants and types for the alarm clock mode controller.
// Holds the state encoding, BCD digit limits and the hour:minute setpoint layout.
package alarm_clock_pkg;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] CLOCK     = 2'd0;
    localparam logic [STATE_W-1:0] SET_TIME  = 2'd1;
    localparam logic [STATE_W-1:0] SET_ALARM = 2'd2;
    localparam logic [STATE_W-1:0] RINGING   = 2'd3;

    localparam int unsigned MIN_T_MAX      = 5;
    localparam int unsigned HR_T_MAX       = 2;
    localparam int unsigned HR_U_MAX_AT_20 = 3;

    localparam int unsigned RING_TICKS_DEF = 60;
    localparam int unsigned RING_CNT_W     = 6;

    // Adjust pulse vector bit positions
    localparam int unsigned PULSE_W     = 4;
    localparam int unsigned P_UP_MIN    = 3;
    localparam int unsigned P_DOWN_MIN  = 2;
    localparam int unsigned P_UP_HOUR   = 1;
    localparam int unsigned P_DOWN_HOUR = 0;

    typedef struct packed {
        logic [1:0] hr_t;
        logic [3:0] hr_u;
        logic [2:0] min_t;
        logic [3:0] min_u;
    } hm_t;

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// Button, tick and live-time inputs plus the control/setpoint outputs of the mode controller.
// master = debouncer/time-counter side, slave = the controller.
interface alarm_clock_ctrl_if;
    logic       tick_1hz;
    logic       btn_c;
    logic       btn_l;
    logic       btn_r;
    logic       btn_u;
    logic       btn_d;
    logic [3:0] sec_u;
    logic [2:0] sec_t;
    logic [3:0] min_u;
    logic [2:0] min_t;
    logic [3:0] hr_u;
    logic [1:0] hr_t;

    logic       cnt_en;
    logic       c_up_min;
    logic       c_down_min;
    logic       c_up_hour;
    logic       c_down_hour;
    logic [3:0] al_min_u;
    logic [2:0] al_min_t;
    logic [3:0] al_hr_u;
    logic [1:0] al_hr_t;
    logic [1:0] mode;
    logic       sel_hour;
    logic       armed;
    logic       buzzer;

    modport master (
        output tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d,
               sec_u, sec_t, min_u, min_t, hr_u, hr_t,
        input  cnt_en, c_up_min, c_down_min, c_up_hour, c_down_hour,
               al_min_u, al_min_t, al_hr_u, al_hr_t, mode, sel_hour, armed, buzzer
    );

    modport slave (
        input  tick_1hz, btn_c, btn_l, btn_r, btn_u, btn_d,
               sec_u, sec_t, min_u, min_t, hr_u, hr_t,
        output cnt_en, c_up_min, c_down_min, c_up_hour, c_down_hour,
               al_min_u, al_min_t, al_hr_u, al_hr_t, mode, sel_hour, armed, buzzer
    );
endinterface

// File: rtl/alarm_clock_ctrl_bcd_hm_adjust.sv
// Combinational BCD hour:minute stepper; minutes wrap 59<->00 without touching hours,
// hours wrap 23<->00. Never produces an invalid BCD value from a valid input.
module bcd_hm_adjust
    import alarm_clock_pkg::*;
(
    input  hm_t  cur,
    input  logic up,
    input  logic down,
    input  logic sel_hour,
    output hm_t  nxt
);

    always_comb begin
        nxt = cur;
        if (up && !sel_hour) begin
            if (cur.min_u == 4'd9) begin
                nxt.min_u = 4'd0;
                nxt.min_t = (cur.min_t == 3'(MIN_T_MAX)) ? 3'd0 : cur.min_t + 3'd1;
            end else begin
                nxt.min_u = cur.min_u + 4'd1;
            end
        end else if (down && !sel_hour) begin
            if (cur.min_u == 4'd0) begin
                nxt.min_u = 4'd9;
                nxt.min_t = (cur.min_t == 3'd0) ? 3'(MIN_T_MAX) : cur.min_t - 3'd1;
            end else begin
                nxt.min_u = cur.min_u - 4'd1;
            end
        end else if (up && sel_hour) begin
            if (cur.hr_t == 2'(HR_T_MAX) && cur.hr_u == 4'(HR_U_MAX_AT_20)) begin
                nxt.hr_t = 2'd0;
                nxt.hr_u = 4'd0;
            end else if (cur.hr_u == 4'd9) begin
                nxt.hr_u = 4'd0;
                nxt.hr_t = cur.hr_t + 2'd1;
            end else begin
                nxt.hr_u = cur.hr_u + 4'd1;
            end
        end else if (down && sel_hour) begin
            if (cur.hr_t == 2'd0 && cur.hr_u == 4'd0) begin
                nxt.hr_t = 2'(HR_T_MAX);
                nxt.hr_u = 4'(HR_U_MAX_AT_20);
            end else if (cur.hr_u == 4'd0) begin
                nxt.hr_u = 4'd9;
                nxt.hr_t = cur.hr_t - 2'd1;
            end else begin
                nxt.hr_u = cur.hr_u - 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock mode controller: button FSM, time-counter enable/adjust pulses,
// alarm setpoint register, alarm match detection and ring sequencing.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned RING_TICKS = RING_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    alarm_clock_ctrl_if.slave bus
);

    logic [STATE_W-1:0]    state_q, state_n;
    logic                  sel_q, sel_n;
    logic                  armed_q, armed_n;
    logic [PULSE_W-1:0]    pulse_q, pulse_n;
    logic [RING_CNT_W-1:0] ring_q, ring_n, ring_inc;
    hm_t                   al_q, al_n;
    logic                  al_up, al_dn;
    logic                  match_c, match_q, match_rise, last_tick, any_btn;

    bcd_hm_adjust u_al_adjust (
        .cur      (al_q),
        .up       (al_up),
        .down     (al_dn),
        .sel_hour (sel_q),
        .nxt      (al_n)
    );

    assign match_c = armed_q
                  && ({bus.hr_t, bus.hr_u, bus.min_t, bus.min_u} == al_q)
                  && (bus.sec_t == 3'd0) && (bus.sec_u == 4'd0);
    assign match_rise = match_c && !match_q;
    assign ring_inc   = ring_q + RING_CNT_W'(1);
    assign last_tick  = bus.tick_1hz && (ring_inc == RING_CNT_W'(RING_TICKS));
    assign any_btn    = bus.btn_c | bus.btn_l | bus.btn_r | bus.btn_u | bus.btn_d;

    // Next-state logic; the if/else order is the button priority c > l > r > u > d
    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        armed_n = armed_q;
        pulse_n = '0;
        ring_n  = ring_q;
        al_up   = 1'b0;
        al_dn   = 1'b0;
        case (state_q)
            CLOCK: begin
                if (match_rise) begin
                    state_n = RINGING;
                    ring_n  = '0;
                end else if (bus.btn_c) begin
                    state_n = SET_TIME;
                    sel_n   = 1'b0;
                end else if (!bus.btn_l && !bus.btn_r && bus.btn_u) begin
                    armed_n = !armed_q;
                end
            end
            SET_TIME: begin
                if (bus.btn_c) begin
                    state_n = SET_ALARM;
                    sel_n   = 1'b0;
                end else if (bus.btn_l) begin
                    sel_n = 1'b1;
                end else if (bus.btn_r) begin
                    sel_n = 1'b0;
                end else if (bus.btn_u) begin
                    if (sel_q) pulse_n[P_UP_HOUR] = 1'b1;
                    else       pulse_n[P_UP_MIN]  = 1'b1;
                end else if (bus.btn_d) begin
                    if (sel_q) pulse_n[P_DOWN_HOUR] = 1'b1;
                    else       pulse_n[P_DOWN_MIN]  = 1'b1;
                end
            end
            SET_ALARM: begin
                if (bus.btn_c) begin
                    state_n = CLOCK;
                    armed_n = 1'b1;
                end else if (bus.btn_l) begin
                    sel_n = 1'b1;
                end else if (bus.btn_r) begin
                    sel_n = 1'b0;
                end else if (bus.btn_u) begin
                    al_up = 1'b1;
                end else if (bus.btn_d) begin
                    al_dn = 1'b1;
                end
            end
            RINGING: begin
                if (any_btn || last_tick) begin
                    state_n = CLOCK;
                end else if (bus.tick_1hz) begin
                    ring_n = ring_inc;
                end
            end
            default: state_n = CLOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLOCK;
            sel_q   <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= '0;
            ring_q  <= '0;
            al_q    <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            armed_q <= armed_n;
            pulse_q <= pulse_n;
            ring_q  <= ring_n;
            al_q    <= al_n;
            match_q <= match_c;
        end
    end

    assign bus.cnt_en      = (state_q != SET_TIME) && bus.tick_1hz;
    assign bus.buzzer      = (state_q == RINGING);
    assign bus.mode        = state_q;
    assign bus.sel_hour    = sel_q;
    assign bus.armed       = armed_q;
    assign bus.c_up_min    = pulse_q[P_UP_MIN];
    assign bus.c_down_min  = pulse_q[P_DOWN_MIN];
    assign bus.c_up_hour   = pulse_q[P_UP_HOUR];
    assign bus.c_down_hour = pulse_q[P_DOWN_HOUR];
    assign bus.al_hr_t     = al_q.hr_t;
    assign bus.al_hr_u     = al_q.hr_u;
    assign bus.al_min_t    = al_q.min_t;
    assign bus.al_min_u    = al_q.min_u;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Scoreboard bench for alarm_clock_ctrl: stimulus queues expected values, a negedge
// monitor pops and compares them, and matches every adjust pulse against its own queue.
module tb_alarm_clock_ctrl;
    import alarm_clock_pkg::*;

    localparam int unsigned RT = 3;

    localparam int F_MODE = 0, F_CNT = 1, F_BUZ = 2, F_ARM = 3, F_SEL = 4, F_AL = 5;
    localparam logic [3:0] P_UM = 4'b1000, P_DM = 4'b0100, P_UH = 4'b0010;
    localparam logic [4:0] B_C = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                           B_U = 5'b00010, B_D = 5'b00001, B_0 = 5'b00000;

    typedef struct {
        int          due;
        int          fld;
        logic [15:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t eq[$];
    logic [3:0] pq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alarm_clock_ctrl_if bus();

    alarm_clock_ctrl #(.RING_TICKS(RT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] hm(int h, int m);
        return 16'({2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)});
    endfunction

    function automatic logic [15:0] actual(int f);
        case (f)
            F_MODE:  return 16'(bus.mode);
            F_CNT:   return 16'(bus.cnt_en);
            F_BUZ:   return 16'(bus.buzzer);
            F_ARM:   return 16'(bus.armed);
            F_SEL:   return 16'(bus.sel_hour);
            default: return 16'({bus.al_hr_t, bus.al_hr_u, bus.al_min_t, bus.al_min_u});
        endcase
    endfunction

    task automatic expect_at(int d, int f, logic [15:0] v, string nm);
        exp_t e;
        e.due = cyc + d;
        e.fld = f;
        e.val = v;
        e.nm  = nm;
        eq.push_back(e);
    endtask

    task automatic drive(logic [4:0] b, logic tk);
        {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = b;
        bus.tick_1hz = tk;
        @(posedge clk);
        #1;
        {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = 5'b0;
        bus.tick_1hz = 1'b0;
    endtask

    task automatic set_time(int h, int m, int s);
        bus.hr_t  = 2'(h / 10);
        bus.hr_u  = 4'(h % 10);
        bus.min_t = 3'(m / 10);
        bus.min_u = 4'(m % 10);
        bus.sec_t = 3'(s / 10);
        bus.sec_u = 4'(s % 10);
    endtask

    // Monitor: compares due expectations and every adjust pulse the DUT presents
    always @(negedge clk) begin
        logic [15:0] a;
        logic [3:0]  p;
        logic [3:0]  ex;
        for (int i = int'(eq.size()) - 1; i >= 0; i--) begin
            if (eq[i].due <= cyc) begin
                checks++;
                a = actual(eq[i].fld);
                if (eq[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s not sampled in time (cycle %0d)", eq[i].nm, cyc);
                end else if (a !== eq[i].val) begin
                    errors++;
                    $display("FAIL %s actual=%0h expected=%0h (cycle %0d)",
                             eq[i].nm, a, eq[i].val, cyc);
                end
                eq.delete(i);
            end
        end
        p = {bus.c_up_min, bus.c_down_min, bus.c_up_hour, bus.c_down_hour};
        if (p != 4'b0) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse actual=%b expected=none (cycle %0d)", p, cyc);
            end else begin
                ex = pq.pop_front();
                if (p !== ex) begin
                    errors++;
                    $display("FAIL adjust_pulse actual=%b expected=%b (cycle %0d)", p, ex, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = 5'b0;
        bus.tick_1hz = 1'b0;
        set_time(12, 0, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        expect_at(0, F_MODE, 16'd0, "rst_mode");
        expect_at(0, F_ARM, 16'd0, "rst_armed");
        expect_at(0, F_BUZ, 16'd0, "rst_buzzer");
        expect_at(0, F_SEL, 16'd0, "rst_sel");
        expect_at(0, F_AL, hm(0, 0), "rst_setpoint");
        drive(B_0, 1'b0);

        // CLOCK: cnt_en follows tick, btn_u toggles armed
        expect_at(0, F_CNT, 16'd1, "clock_cnt_en_tick");
        drive(B_0, 1'b1);
        expect_at(0, F_CNT, 16'd0, "clock_cnt_en_idle");
        drive(B_0, 1'b0);
        expect_at(1, F_ARM, 16'd1, "arm_toggle_on");
        drive(B_U, 1'b0);
        expect_at(1, F_ARM, 16'd0, "arm_toggle_off");
        drive(B_U, 1'b0);

        // Priority: btn_c wins over btn_u
        expect_at(1, F_MODE, 16'd1, "prio_mode");
        expect_at(1, F_ARM, 16'd0, "prio_armed");
        drive(B_C | B_U, 1'b0);

        // SET_TIME
        expect_at(0, F_CNT, 16'd0, "settime_cnt_en_frozen");
        expect_at(1, F_MODE, 16'd1, "settime_stay");
        drive(B_0, 1'b1);
        expect_at(1, F_SEL, 16'd1, "settime_sel_hour");
        drive(B_L, 1'b0);
        pq.push_back(P_UH);
        drive(B_U, 1'b0);
        pq.push_back(P_UH);
        drive(B_U, 1'b0);
        expect_at(1, F_SEL, 16'd0, "settime_sel_min");
        drive(B_R, 1'b0);
        pq.push_back(P_DM);
        drive(B_D, 1'b0);
        pq.push_back(P_UM);
        drive(B_U, 1'b0);
        expect_at(1, F_SEL, 16'd1, "settime_prio_l_over_d");
        drive(B_L | B_D, 1'b0);
        expect_at(0, F_CNT, 16'd0, "settime_cnt_en_frozen2");
        drive(B_0, 1'b1);
        expect_at(1, F_MODE, 16'd2, "to_setalarm");
        expect_at(1, F_SEL, 16'd0, "setalarm_sel_cleared");
        drive(B_C, 1'b0);

        // SET_ALARM arithmetic
        expect_at(1, F_AL, hm(0, 59), "al_min_down_wrap0");
        drive(B_D, 1'b0);
        drive(B_L, 1'b0);
        for (int h = 1; h <= 23; h++) begin
            expect_at(1, F_AL, hm(h, 59), "al_hr_up_step");
            drive(B_U, 1'b0);
        end
        expect_at(1, F_AL, hm(0, 59), "al_hr_up_wrap");
        drive(B_U, 1'b0);
        expect_at(1, F_SEL, 16'd0, "al_sel_min");
        drive(B_R, 1'b0);
        expect_at(1, F_AL, hm(0, 0), "al_min_up_wrap");
        drive(B_U, 1'b0);
        expect_at(1, F_AL, hm(0, 59), "al_min_down_wrap");
        drive(B_D, 1'b0);
        drive(B_L, 1'b0);
        expect_at(1, F_AL, hm(23, 59), "al_hr_down_wrap");
        drive(B_D, 1'b0);
        for (int h = 22; h >= 7; h--) begin
            expect_at(1, F_AL, hm(h, 59), "al_hr_down_step");
            drive(B_D, 1'b0);
        end
        drive(B_R, 1'b0);
        for (int m = 58; m >= 30; m--) begin
            expect_at(1, F_AL, hm(7, m), "al_min_down_step");
            drive(B_D, 1'b0);
        end
        expect_at(0, F_CNT, 16'd1, "setalarm_cnt_en_tick");
        expect_at(1, F_MODE, 16'd2, "setalarm_stay");
        drive(B_0, 1'b1);
        expect_at(1, F_MODE, 16'd0, "setalarm_exit");
        expect_at(1, F_ARM, 16'd1, "setalarm_arms");
        expect_at(1, F_AL, hm(7, 30), "al_setpoint_0730");
        drive(B_C, 1'b0);

        // Ring and dismiss
        set_time(7, 29, 59);
        expect_at(1, F_MODE, 16'd0, "pre_match_idle");
        drive(B_0, 1'b0);
        set_time(7, 30, 0);
        expect_at(1, F_MODE, 16'd3, "ring_enter");
        expect_at(1, F_BUZ, 16'd1, "ring_buzzer");
        drive(B_0, 1'b0);
        expect_at(0, F_CNT, 16'd1, "ring_cnt_en");
        expect_at(1, F_MODE, 16'd3, "ring_stay_tick1");
        drive(B_0, 1'b1);
        expect_at(1, F_MODE, 16'd0, "dismiss_mode");
        expect_at(1, F_BUZ, 16'd0, "dismiss_buzzer");
        expect_at(1, F_ARM, 16'd1, "dismiss_armed");
        drive(B_D, 1'b0);
        expect_at(1, F_MODE, 16'd0, "no_retrigger1");
        drive(B_0, 1'b0);
        expect_at(1, F_MODE, 16'd0, "no_retrigger2");
        drive(B_0, 1'b0);

        // Final tick coincident with btn_c
        set_time(7, 30, 1);
        drive(B_0, 1'b0);
        set_time(7, 30, 0);
        expect_at(1, F_MODE, 16'd3, "ring2_enter");
        drive(B_0, 1'b0);
        expect_at(1, F_MODE, 16'd3, "ring2_tick1");
        drive(B_0, 1'b1);
        drive(B_0, 1'b0);
        expect_at(1, F_MODE, 16'd3, "ring2_tick2");
        drive(B_0, 1'b1);
        expect_at(1, F_MODE, 16'd0, "tick3_with_btn_c_mode");
        expect_at(1, F_BUZ, 16'd0, "tick3_with_btn_c_buzzer");
        drive(B_C, 1'b1);
        expect_at(1, F_MODE, 16'd0, "tick3_with_btn_c_no_settime");
        drive(B_0, 1'b0);

        // Pure timeout after RING_TICKS ticks
        set_time(7, 30, 1);
        drive(B_0, 1'b0);
        set_time(7, 30, 0);
        expect_at(1, F_MODE, 16'd3, "ring3_enter");
        drive(B_0, 1'b0);
        expect_at(1, F_MODE, 16'd3, "ring3_tick1");
        drive(B_0, 1'b1);
        expect_at(1, F_MODE, 16'd3, "ring3_tick2");
        drive(B_0, 1'b1);
        expect_at(1, F_MODE, 16'd0, "ring3_timeout");
        expect_at(1, F_ARM, 16'd1, "ring3_timeout_armed");
        drive(B_0, 1'b1);

        // Reset while ringing
        set_time(7, 30, 1);
        drive(B_0, 1'b0);
        set_time(7, 30, 0);
        expect_at(1, F_BUZ, 16'd1, "ring4_buzzer");
        drive(B_0, 1'b0);
        reset = 1'b0;
        expect_at(1, F_MODE, 16'd0, "ringrst_mode");
        expect_at(1, F_BUZ, 16'd0, "ringrst_buzzer");
        expect_at(1, F_AL, hm(0, 0), "ringrst_setpoint");
        expect_at(1, F_ARM, 16'd0, "ringrst_armed");
        expect_at(1, F_SEL, 16'd0, "ringrst_sel");
        drive(B_0, 1'b0);
        reset = 1'b1;
        expect_at(1, F_MODE, 16'd0, "post_reset_idle");
        drive(B_0, 1'b0);

        repeat (3) drive(B_0, 1'b0);

        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL pulses_outstanding actual=%0d expected=0", pq.size());
        end
        checks++;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL expectations_outstanding actual=%0d expected=0", eq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
